// File: rtl/adder_bist_if.sv
// Streaming handshake bundle between adder_bist and the adder under test.
// master = BIST side (drives operands, sinks results); slave = adder side.
interface adder_bist_if #(
    parameter int WIDTH = 32
) ();
    logic             o_req;
    logic [WIDTH-1:0] o_data;
    logic [WIDTH-1:0] o_datb;
    logic             i_ack;
    logic             i_req;
    logic [WIDTH-1:0] i_datc;
    logic             o_ack;

    modport master (
        output o_req, o_data, o_datb, o_ack,
        input  i_ack, i_req, i_datc
    );

    modport slave (
        input  o_req, o_data, o_datb, o_ack,
        output i_ack, i_req, i_datc
    );
endinterface

// File: rtl/adder_bist.sv
// Self-test traffic generator and result checker for the req/ack adder.
// Optional ADDER_BIST_ERR_INJECT_EN plants tagged, deliberately wrong expectations.
module adder_bist #(
    parameter int          WIDTH   = 32,
    parameter int          DEPTH   = 8,
    parameter int          NUM_TXN = 1000,
    parameter logic [31:0] SEED    = 32'h1,
    parameter int          TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    adder_bist_if.master bus,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_pass,
    output logic         o_timeout,
    output logic         o_unexpected,
    output logic [31:0]  o_checked,
    output logic [31:0]  o_passed,
    output logic [31:0]  o_errors,
    output logic [31:0]  o_induced
);

    localparam logic [31:0] TAPS   = 32'h80200003;
    localparam logic [31:0] SEED_A = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] SEED_B = (~SEED_A == 32'h0) ? 32'h1 : ~SEED_A;
    localparam int          AW     = $clog2(DEPTH);
`ifdef ADDER_BIST_ERR_INJECT_EN
    localparam int          FW     = WIDTH + 1;
`else
    localparam int          FW     = WIDTH;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] x, input logic [1:0] n);
        logic [32:0] s;
        s = {1'b0, x} + {31'b0, n};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_to_timeout;

    logic [31:0]      r_lfsr_a;
    logic [31:0]      r_lfsr_b;
    logic [31:0]      r_issued;
    logic [31:0]      r_idle;
    logic [FW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic             r_vld_p1;
    logic [WIDTH-1:0] r_exp_p1;
    logic [WIDTH-1:0] r_res_p1;

    logic [31:0]      r_checked;
    logic [31:0]      r_passed;
    logic [31:0]      r_errors;
    logic             r_timeout;
    logic             r_unexpected;

    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_sum;
    logic [FW-1:0]    w_entry;
    logic             w_run;
    logic             w_drain;
    logic             w_full;
    logic             w_launch;
    logic             w_op_fire;
    logic             w_res_fire;
    logic             w_pop;
    logic             w_unexp;
    logic             w_inc_pass;
    logic             w_inc_err;
    logic [1:0]       w_err_n;
`ifdef ADDER_BIST_ERR_INJECT_EN
    logic             w_tag;
    logic             r_tag_p1;
    logic             w_inc_ind;
    logic [31:0]      r_induced;
`endif

    // ---- p0: operand generation and handshake decode ----
    always_comb begin
        w_opa            = WIDTH'(r_lfsr_a);
        w_opa[WIDTH-1]   = 1'b0;
        w_opb            = WIDTH'(r_lfsr_b);
        w_opb[WIDTH-1]   = 1'b0;
        w_sum            = w_opa + w_opb;
`ifdef ADDER_BIST_ERR_INJECT_EN
        w_tag            = (r_lfsr_a[3:0] == 4'h1);
        w_entry          = {w_tag, w_sum ^ {w_tag, {(WIDTH-1){1'b0}}}};
`else
        w_entry          = w_sum;
`endif
    end

    assign w_run      = (r_state == S_RUN);
    assign w_drain    = (r_state == S_DRAIN);
    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_launch   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign bus.o_req  = w_run && !w_full;
    assign bus.o_data = bus.o_req ? w_opa : '0;
    assign bus.o_datb = bus.o_req ? w_opb : '0;
    assign bus.o_ack  = w_run || w_drain;

    assign w_op_fire  = bus.o_req && bus.i_ack;
    assign w_res_fire = bus.i_req && bus.o_ack;
    assign w_pop      = w_res_fire && (r_count != '0);
    assign w_unexp    = w_res_fire && (r_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_to_timeout = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_op_fire && (r_issued == 32'(NUM_TXN - 1))) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if ((r_count == '0) && !r_vld_p1) begin
                    w_state_nxt = S_DONE;
                end else if (!w_res_fire && (r_idle == 32'(TIMEOUT - 1))) begin
                    w_state_nxt  = S_DONE;
                    w_to_timeout = 1'b1;
                end
            end
            S_DONE:  if (i_start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Expected-sum FIFO storage and the compare register carry no reset.
    always_ff @(posedge clk) begin
        if (w_op_fire) r_mem[r_wptr] <= w_entry;
        if (w_pop) begin
            r_exp_p1 <= r_mem[r_rptr][WIDTH-1:0];
            r_res_p1 <= bus.i_datc;
`ifdef ADDER_BIST_ERR_INJECT_EN
            r_tag_p1 <= r_mem[r_rptr][WIDTH];
`endif
        end
    end

    // ---- p1: compare stage, outcome classification ----
    always_comb begin
        w_inc_pass = 1'b0;
        w_inc_err  = 1'b0;
`ifdef ADDER_BIST_ERR_INJECT_EN
        w_inc_ind  = 1'b0;
        if (r_vld_p1) begin
            if (r_tag_p1) begin
                if (r_exp_p1 == r_res_p1) w_inc_err = 1'b1;
                else begin
                    w_inc_pass = 1'b1;
                    w_inc_ind  = 1'b1;
                end
            end else if (r_exp_p1 == r_res_p1) w_inc_pass = 1'b1;
            else                                w_inc_err  = 1'b1;
        end
`else
        if (r_vld_p1) begin
            if (r_exp_p1 == r_res_p1) w_inc_pass = 1'b1;
            else                      w_inc_err  = 1'b1;
        end
`endif
    end

    // An unexpected result and a compare error can land in the same cycle.
    assign w_err_n = {1'b0, w_inc_err} + {1'b0, w_unexp};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr_a     <= SEED_A;
            r_lfsr_b     <= SEED_B;
            r_issued     <= '0;
            r_idle       <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_vld_p1     <= 1'b0;
            r_checked    <= '0;
            r_passed     <= '0;
            r_errors     <= '0;
            r_timeout    <= 1'b0;
            r_unexpected <= 1'b0;
`ifdef ADDER_BIST_ERR_INJECT_EN
            r_induced    <= '0;
`endif
        end else if (w_launch) begin
            r_lfsr_a     <= SEED_A;
            r_lfsr_b     <= SEED_B;
            r_issued     <= '0;
            r_idle       <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_vld_p1     <= 1'b0;
            r_checked    <= '0;
            r_passed     <= '0;
            r_errors     <= '0;
            r_timeout    <= 1'b0;
            r_unexpected <= 1'b0;
`ifdef ADDER_BIST_ERR_INJECT_EN
            r_induced    <= '0;
`endif
        end else begin
            if (w_op_fire) begin
                r_lfsr_a <= lfsr_step(r_lfsr_a);
                r_lfsr_b <= lfsr_step(r_lfsr_b);
                r_wptr   <= r_wptr + AW'(1);
                r_issued <= r_issued + 32'd1;
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_op_fire, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            r_vld_p1 <= w_pop;
            if (w_drain) r_idle <= w_res_fire ? 32'd0 : r_idle + 32'd1;
            if (w_to_timeout) r_timeout <= 1'b1;
            if (w_unexp) r_unexpected <= 1'b1;
            r_checked <= sat_add(r_checked, {1'b0, r_vld_p1});
            r_passed  <= sat_add(r_passed, {1'b0, w_inc_pass});
            r_errors  <= sat_add(r_errors, w_err_n);
`ifdef ADDER_BIST_ERR_INJECT_EN
            r_induced <= sat_add(r_induced, {1'b0, w_inc_ind});
`endif
        end
    end

    assign o_busy       = w_run || w_drain;
    assign o_done       = (r_state == S_DONE);
    assign o_pass       = o_done && (r_errors == '0) && !r_timeout && !r_unexpected &&
                          (r_checked == 32'(NUM_TXN));
    assign o_timeout    = r_timeout;
    assign o_unexpected = r_unexpected;
    assign o_checked    = r_checked;
    assign o_passed     = r_passed;
    assign o_errors     = r_errors;
`ifdef ADDER_BIST_ERR_INJECT_EN
    assign o_induced    = r_induced;
`else
    assign o_induced    = '0;
`endif

endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist: a behavioural 1-cycle adder on the slave side,
// a scenario table for full runs, and hand sequences for the multi-cycle corners.
module tb_adder_bist;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int NUM_TXN = 10;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        o_busy, o_done, o_pass, o_timeout, o_unexpected;
    logic [31:0] o_checked, o_passed, o_errors, o_induced;

    adder_bist_if #(.WIDTH(WIDTH)) bus ();

    adder_bist #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_TXN(NUM_TXN), .SEED(32'h1), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rst(rst), .i_start(i_start), .bus(bus),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
        .o_unexpected(o_unexpected), .o_checked(o_checked), .o_passed(o_passed),
        .o_errors(o_errors), .o_induced(o_induced)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Adder model controls and bookkeeping
    int          ack_mode;      // 0: always ready, 1: alternate, 2: never
    bit          res_en;
    bit          stall_drain;
    int          corrupt_idx;
    bit          bp_check;
    bit          inj_req;
    logic [31:0] q[$];
    int          op_cnt, res_cnt, cyc;
    logic [31:0] op_a_log [16];
    logic [31:0] op_b_log [16];
    bit          p_op, p_res_q, p_hold;
    logic [31:0] p_a, p_b, h_a, h_b;

    initial begin
        bus.i_ack  = 1'b0;
        bus.i_req  = 1'b0;
        bus.i_datc = '0;
        cyc = 0;
        forever begin
            bit injected;
            @(negedge clk);
            cyc++;
            injected = 1'b0;
            if (p_op) begin
                q.push_back(p_a + p_b);
                if (op_cnt < 16) begin
                    op_a_log[op_cnt] = p_a;
                    op_b_log[op_cnt] = p_b;
                end
                op_cnt++;
            end
            if (p_res_q) begin
                void'(q.pop_front());
                res_cnt++;
            end
            if (bp_check && p_hold) begin
                check("bp_req_hold", 32'(bus.o_req), 32'd1);
                check("bp_data_hold", bus.o_data, h_a);
                check("bp_datb_hold", bus.o_datb, h_b);
            end
            case (ack_mode)
                0:       bus.i_ack = 1'b1;
                1:       bus.i_ack = cyc[0];
                default: bus.i_ack = 1'b0;
            endcase
            if (inj_req) begin
                bus.i_req  = 1'b1;
                bus.i_datc = 32'hDEAD_BEEF;
                inj_req    = 1'b0;
                injected   = 1'b1;
            end else if (res_en && !(stall_drain && op_cnt >= NUM_TXN) && q.size() > 0) begin
                bus.i_req  = 1'b1;
                bus.i_datc = q[0] ^ ((res_cnt == corrupt_idx) ? 32'h1 : 32'h0);
            end else begin
                bus.i_req  = 1'b0;
            end
            p_op    = bus.o_req && bus.i_ack;
            p_a     = bus.o_data;
            p_b     = bus.o_datb;
            p_res_q = bus.i_req && bus.o_ack && !injected;
            p_hold  = bus.o_req && !bus.i_ack;
            h_a     = bus.o_data;
            h_b     = bus.o_datb;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic model_clear();
        q.delete();
        p_op    = 1'b0;
        p_res_q = 1'b0;
        p_hold  = 1'b0;
        op_cnt  = 0;
        res_cnt = 0;
    endtask

    task automatic start_run(input string tag);
        model_clear();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(o_busy), 32'd1);
        check({tag, "_req_after_start"}, 32'(bus.o_req), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k;
        k = 0;
        while (!o_done && k < bound) begin
            step();
            k++;
        end
        check({tag, "_done"}, 32'(o_done), 32'd1);
    endtask

    task automatic wait_ops(input string tag, input int n, input int bound);
        int k;
        k = 0;
        while (op_cnt < n && k < bound) begin
            step();
            k++;
        end
        check({tag, "_ops_reached"}, 32'(op_cnt >= n), 32'd1);
    endtask

    typedef struct {
        int ack_mode;
        int corrupt_idx;
        bit bp;
        int exp_checked;
        int exp_passed;
        int exp_errors;
        bit exp_pass;
    } scen_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    scen_t scen [3];
    op_t   ops  [3];

    task automatic check_ops(input string tag);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("%s_opa%0d", tag, j), op_a_log[j], ops[j].a);
            check($sformatf("%s_opb%0d", tag, j), op_b_log[j], ops[j].b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full runs: baseline, alternating i_ack, bit-0 flip on the 2nd result
        scen[0] = '{0, -1, 1'b0, NUM_TXN, NUM_TXN,     0, 1'b1};
        scen[1] = '{1, -1, 1'b1, NUM_TXN, NUM_TXN,     0, 1'b1};
        scen[2] = '{0,  1, 1'b0, NUM_TXN, NUM_TXN - 1, 1, 1'b0};
        // First three operand pairs for SEED=1, hand-stepped through the Galois LFSR
        ops[0] = '{32'h0000_0001, 32'h7FFF_FFFE};
        ops[1] = '{32'h0020_0003, 32'h7FFF_FFFF};
        ops[2] = '{32'h4030_0002, 32'h3FDF_FFFC};

        ack_mode = 0; res_en = 1'b1; stall_drain = 1'b0; corrupt_idx = -1;
        bp_check = 1'b0; inj_req = 1'b0;
        model_clear();

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_pass", 32'(o_pass), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_unexp", 32'(o_unexpected), 32'd0);
        check("rst_req", 32'(bus.o_req), 32'd0);
        check("rst_ack", 32'(bus.o_ack), 32'd0);
        check("rst_data", bus.o_data, 32'd0);
        check("rst_checked", o_checked, 32'd0);
        check("rst_errors", o_errors, 32'd0);
        check("rst_induced", o_induced, 32'd0);
        rst = 1'b0;
        step();
        check("idle_ack", 32'(bus.o_ack), 32'd0);

        for (int i = 0; i < 3; i++) begin
            string t;
            t = $sformatf("s%0d", i);
            ack_mode    = scen[i].ack_mode;
            corrupt_idx = scen[i].corrupt_idx;
            bp_check    = scen[i].bp;
            start_run(t);
            wait_done(t, 300);
            bp_check = 1'b0;
            check({t, "_checked"}, o_checked, 32'(scen[i].exp_checked));
            check({t, "_passed"}, o_passed, 32'(scen[i].exp_passed));
            check({t, "_errors"}, o_errors, 32'(scen[i].exp_errors));
            check({t, "_pass"}, 32'(o_pass), 32'(scen[i].exp_pass));
            check({t, "_timeout"}, 32'(o_timeout), 32'd0);
            check({t, "_ops"}, 32'(op_cnt), 32'(NUM_TXN));
            check({t, "_ack_done"}, 32'(bus.o_ack), 32'd0);
            check_ops(t);
        end
        corrupt_idx = -1;

        // FIFO full: results withheld, exactly DEPTH operands accepted
        ack_mode = 0; res_en = 1'b0;
        start_run("full");
        repeat (20) step();
        check("full_ops", 32'(op_cnt), 32'(DEPTH));
        check("full_req_low", 32'(bus.o_req), 32'd0);
        check("full_checked", o_checked, 32'd0);
        res_en = 1'b1;
        step();
        check("full_req_after_pop", 32'(bus.o_req), 32'd1);
        wait_done("full", 300);
        check("full_final_checked", o_checked, 32'(NUM_TXN));
        check("full_final_pass", 32'(o_pass), 32'd1);

        // Unexpected result while nothing is outstanding
        ack_mode = 2; res_en = 1'b1;
        start_run("unx");
        inj_req = 1'b1;
        step();
        check("unx_flag", 32'(o_unexpected), 32'd1);
        check("unx_errors", o_errors, 32'd1);
        check("unx_checked", o_checked, 32'd0);
        ack_mode = 0;
        wait_done("unx", 300);
        check("unx_final_passed", o_passed, 32'(NUM_TXN));
        check("unx_final_errors", o_errors, 32'd1);
        check("unx_final_pass", 32'(o_pass), 32'd0);

        // Last result stalled in DRAIN
        ack_mode = 0; res_en = 1'b1; stall_drain = 1'b1;
        start_run("tmo");
        wait_ops("tmo", NUM_TXN, 100);
        repeat (TIMEOUT - 5) step();
        check("tmo_not_early", 32'(o_done), 32'd0);
        check("tmo_busy", 32'(o_busy), 32'd1);
        wait_done("tmo", 30);
        check("tmo_flag", 32'(o_timeout), 32'd1);
        check("tmo_pass", 32'(o_pass), 32'd0);
        check("tmo_checked", o_checked, 32'(NUM_TXN - 1));
        stall_drain = 1'b0;

        // Reset mid-run, then a fresh run replays the same operands
        ack_mode = 0; res_en = 1'b1;
        start_run("mrst");
        wait_ops("mrst", 3, 20);
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(o_busy), 32'd0);
        check("mrst_req", 32'(bus.o_req), 32'd0);
        check("mrst_ack", 32'(bus.o_ack), 32'd0);
        check("mrst_checked", o_checked, 32'd0);
        check("mrst_passed", o_passed, 32'd0);
        model_clear();
        step();
        rst = 1'b0;
        step();
        check("mrst_idle", 32'(o_busy), 32'd0);
        start_run("mrst2");
        wait_done("mrst2", 300);
        check("mrst2_checked", o_checked, 32'(NUM_TXN));
        check("mrst2_pass", 32'(o_pass), 32'd1);
        check_ops("mrst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
